// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg
// Shared types and constants for the core's store path.
//   XLEN        : address / data width of the core
//   sb_state_t  : drain state machine of the store buffer
//   sb_entry_t  : one buffered store (byte address + data)
//   SB_FULL_STRB: byte enables used for every drained write
// ---------------------------------------------------------------------------
package npc_pkg;

  localparam int XLEN = 64;

  localparam logic [7:0] SB_FULL_STRB = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// ---------------------------------------------------------------------------
// sb_fifo
// Circular queue of DEPTH store entries for the store buffer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers/count only)
//   i_push        : write i_pushEntry at the tail (ignored when full)
//   i_pushEntry   : entry to enqueue
//   i_pop         : drop the head entry (ignored when empty)
//   o_headEntry   : entry at the head, valid whenever o_empty is low
//   o_count       : number of entries held
//   o_full        : count == DEPTH
//   o_empty       : count == 0
// ---------------------------------------------------------------------------
module sb_fifo
  import npc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  sb_entry_t                  i_pushEntry,
  input  logic                       i_pop,
  output sb_entry_t                  o_headEntry,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_doPush;
  logic               w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  assign o_headEntry = r_mem[r_head];

  // Entry storage carries no reset: an entry is only ever read after it
  // has been written, so its power-up contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_tail] <= i_pushEntry;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_doPop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Decouples core stores from memory: stores are queued and drained one
// write at a time, strictly in order, as full 8-byte aligned writes.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   st_valid        : core presents a store
//   st_addr/st_data : store byte address / data
//   st_ready        : a slot is free (core stalls when st_valid && !st_ready)
//   mem_req_valid   : write request presented to memory
//   mem_req_ready   : memory accepts the request
//   mem_req_addr    : aligned write address
//   mem_req_data    : write data
//   mem_req_strb    : byte enables (always all ones)
//   mem_resp_valid  : one-cycle write completion pulse
//   empty           : nothing queued and no write outstanding
//   misalign_err    : sticky, set by any store with a nonzero st_addr[2:0]
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            st_ready,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_data,
  output logic [7:0]      mem_req_strb,
  input  logic            mem_resp_valid,
  output logic            empty,
  output logic            misalign_err
);

  import npc_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  sb_state_t          r_state;
  logic               r_misalignErr;

  sb_entry_t          w_pushEntry;
  sb_entry_t          w_headEntry;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_fifoEmpty;
  logic               w_push;
  logic               w_pop;

  // st_ready looks only at the registered count, so a slot freed by a pop
  // becomes visible to the core one cycle later.
  assign st_ready = !w_full;
  assign w_push   = st_valid && st_ready;
  assign w_pop    = (r_state == WAIT_RESP) && mem_resp_valid;

  assign w_pushEntry.addr = st_addr;
  assign w_pushEntry.data = st_data;

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pushEntry (w_pushEntry),
    .i_pop       (w_pop),
    .o_headEntry (w_headEntry),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_fifoEmpty)
  );

  // Drain FSM. The head entry cannot change while in REQ (pops only happen
  // in WAIT_RESP), so the request fields stay stable until the handshake.
  // Leaving WAIT_RESP looks at the post-pop count including a same-cycle
  // enqueue, so a store arriving with the response is issued without an
  // IDLE detour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_fifoEmpty) begin
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            r_state <= ((w_count > CNT_W'(1)) || w_push) ? REQ : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Misaligned stores are still queued (and written aligned); the flag only
  // records that one happened, until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalignErr <= 1'b0;
    end else if (w_push && (st_addr[2:0] != 3'b000)) begin
      r_misalignErr <= 1'b1;
    end
  end

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = {w_headEntry.addr[XLEN-1:3], 3'b000};
  assign mem_req_data  = w_headEntry.data;
  assign mem_req_strb  = SB_FULL_STRB;
  assign empty         = w_fifoEmpty && (r_state == IDLE);
  assign misalign_err  = r_misalignErr;

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter XLEN, default 64, meaning address and data width.
REQ-003 The block SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 The block SHALL have port st_valid, input, 1, meaning the core presents a store (driven from memwrite).
REQ-006 The block SHALL have port st_addr, input, XLEN, meaning the store byte address.
REQ-007 The block SHALL have port st_data, input, XLEN, meaning the store data.
REQ-008 The block SHALL have port st_ready, output, 1, meaning space available; the core stalls its PC when st_valid && !st_ready.
REQ-009 The block SHALL have port mem_req_valid, output, 1, meaning a write request is presented.
REQ-010 The block SHALL have port mem_req_ready, input, 1, meaning memory accepts the request.
REQ-011 The block SHALL have port mem_req_addr, output, XLEN, meaning the write address, 8-byte aligned.
REQ-012 The block SHALL have port mem_req_data, output, XLEN, meaning the write data.
REQ-013 The block SHALL have port mem_req_strb, output, 8, meaning byte enables.
REQ-014 The block SHALL have port mem_resp_valid, input, 1, meaning a one-cycle write completion pulse.
REQ-015 The block SHALL have port empty, output, 1, meaning no entries are held and no write is outstanding (used for ebreak/fence drain).
REQ-016 The block SHALL have port misalign_err, output, 1, meaning a sticky flag set by a misaligned store.

Function
REQ-017 st_ready SHALL equal (count < DEPTH), derived from registered count only, with no same-cycle pop bypass.
REQ-018 Enqueue SHALL occur when st_valid && st_ready: {st_addr, st_data} written at the tail, tail pointer +1 modulo DEPTH, with wrap-around.
REQ-019 When st_addr[2:0] != 0, the entry SHALL still be enqueued, with misalign_err set and held until reset.
REQ-020 The drain FSM SHALL have states IDLE, REQ and WAIT_RESP.
REQ-021 IDLE SHALL go to REQ on the cycle after count becomes nonzero.
REQ-022 In REQ, mem_req_valid SHALL be 1, and mem_req_addr = {head.addr[XLEN-1:3], 3'b000}, mem_req_data = head.data, and mem_req_strb = 8'hFF SHALL be held stable until the handshake.
REQ-023 The REQ handshake SHALL be mem_req_valid && mem_req_ready, after which the FSM goes to WAIT_RESP with mem_req_valid low the next cycle.
REQ-024 In WAIT_RESP, mem_resp_valid SHALL pop the head (head +1 modulo DEPTH, count -1), then go to REQ if the post-pop count > 0, else to IDLE.
REQ-025 mem_resp_valid in IDLE or REQ SHALL be ignored, with no state change.
REQ-026 A simultaneous enqueue and pop SHALL leave count unchanged, with both pointers advanced.
REQ-027 At full (count == DEPTH), st_ready = 0 SHALL hold through a same-cycle pop and rise the following cycle.
REQ-028 A single store SHALL have a minimum latency to mem_req_valid of 2 cycles after enqueue (enqueue edge, then IDLE->REQ edge).
REQ-029 At most one write SHALL be outstanding at a time.
REQ-030 empty SHALL equal (count == 0) && (state == IDLE).
REQ-031 Stores SHALL be issued to memory strictly in enqueue order.

Reset
REQ-032 With rst high, the block SHALL set head = tail = count = 0, state = IDLE, and misalign_err = 0.
REQ-033 Outputs during and after reset SHALL be st_ready = 1, mem_req_valid = 0, empty = 1, and mem_req_strb = 8'hFF.
REQ-034 Reset mid-operation (REQ or WAIT_RESP) SHALL discard all entries with no further request; a late mem_resp_valid SHALL be ignored per REQ-025.
REQ-035 Entry storage (addr/data arrays) SHALL NOT require reset.

Structure
REQ-036 The shared package npc_pkg SHALL hold XLEN = 64, the sb_state_t enum {IDLE, REQ, WAIT_RESP}, and the sb_entry_t struct {addr, data}.
REQ-037 A sub-module sb_fifo (DEPTH x sb_entry_t storage, head/tail/count, push/pop/full/empty) SHALL be instantiated; the FSM and misalign logic SHALL live in store_buffer.

Verification
REQ-038 Single store: addr 0x80001000, data 0x1122334455667788, mem_req_ready = 1, resp 1 cycle after accept -> one request with that addr/data and strb 0xFF; empty returns to 1.
REQ-039 Fill: 5 back-to-back stores with mem_req_ready = 0 -> 4 accepted, st_ready = 0 on the 5th; raising ready drains in order 0..3, and the 5th is accepted once a slot frees.
REQ-040 Wrap: 10 stores, addrs 0x80000000 + 8*i, with random ready/resp delays -> 10 writes in order, pointers wrap, and no loss or duplication.
REQ-041 Simultaneous push/pop: at count = 2, a store enqueued in the same cycle as a resp pulse -> count remains 2 and the order is preserved.
REQ-042 Misaligned: addr 0x80000004 -> misalign_err = 1 sticky, request addr 0x80000000; reset clears it.
REQ-043 Reset mid-WAIT_RESP with 3 entries -> empty = 1 next cycle, no mem_req_valid, and a subsequent stray resp is ignored.
